// File: rtl/reglk_ctrl.sv
// reglk_ctrl: owns the register-lock word array, sweeps it to the locked value after reset or a soft
// reset, and arbitrates firmware/JTAG lock writes. Define REGLK_AUDIT_EN to add denial audit outputs.
module reglk_ctrl #(
  parameter int                NUM_REGS = 6,
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b1}},
  localparam int               IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              soft_rst_i,
  input  logic                              boot_done_i,
  input  logic                              jtag_unlock_i,
  input  logic                              fw_req_i,
  input  logic [IDX_W-1:0]                  fw_idx_i,
  input  logic [DATA_W-1:0]                 fw_wdata_i,
  output logic                              fw_gnt_o,
  input  logic                              dbg_req_i,
  input  logic [IDX_W-1:0]                  dbg_idx_i,
  input  logic [DATA_W-1:0]                 dbg_wdata_i,
  output logic                              dbg_gnt_o,
  output logic                              deny_o,
  output logic                              init_done_o,
  output logic [NUM_REGS-1:0][DATA_W-1:0]   reglk_mem_o
`ifdef REGLK_AUDIT_EN
  ,
  output logic [15:0]                       deny_cnt_o,
  output logic [IDX_W-1:0]                  last_deny_idx_o
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                            r_state;
  state_t                            w_state_nxt;
  logic [IDX_W-1:0]                  r_cnt;
  logic [IDX_W-1:0]                  w_cnt_nxt;
  logic [NUM_REGS-1:0][DATA_W-1:0]   r_mem;
  logic                              r_sealed;
  logic                              r_rr_dbg;
  logic                              r_fw_gnt;
  logic                              r_dbg_gnt;
  logic                              r_deny;
  logic                              r_init_done;
  logic                              w_fw_elig;
  logic                              w_dbg_elig;
  logic                              w_fw_win;
  logic                              w_dbg_win;
  logic                              w_ok;
  logic                              w_we;
  logic                              w_deny;
  logic [IDX_W-1:0]                  w_widx;
  logic [DATA_W-1:0]                 w_wdata;

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return (idx <= LAST_IDX);
  endfunction

  // State and sweep-counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, sweep progress and arbitration winner
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fw_win    = 1'b0;
    w_dbg_win   = 1'b0;
    // A requester whose grant is showing this cycle is still holding req; ignore it once.
    w_fw_elig   = fw_req_i & ~r_fw_gnt;
    w_dbg_elig  = dbg_req_i & ~r_dbg_gnt;
    case (r_state)
      ST_INIT: begin
        if (soft_rst_i) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == LAST_IDX) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + IDX_W'(1);
        end
      end
      ST_RUN: begin
        if (soft_rst_i) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end else if (w_fw_elig && w_dbg_elig) begin
          w_fw_win  = ~r_rr_dbg;
          w_dbg_win = r_rr_dbg;
        end else begin
          w_fw_win  = w_fw_elig;
          w_dbg_win = w_dbg_elig;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Write source selection and permission check for the winner
  always_comb begin
    w_widx  = fw_idx_i;
    w_wdata = fw_wdata_i;
    w_ok    = 1'b0;
    if (w_dbg_win) begin
      w_widx  = dbg_idx_i;
      w_wdata = dbg_wdata_i;
      w_ok    = jtag_unlock_i & idx_in_range(dbg_idx_i);
    end else if (w_fw_win) begin
      w_ok    = ~r_sealed & idx_in_range(fw_idx_i);
    end else begin
      w_ok    = 1'b0;
    end
    w_we   = (w_fw_win | w_dbg_win) & w_ok;
    w_deny = (w_fw_win | w_dbg_win) & ~w_ok;
  end

  // Lock word array: reset/sweep to INIT_VAL, otherwise permitted full-word writes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem <= {NUM_REGS{INIT_VAL}};
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_state == ST_INIT) begin
          if (r_cnt == IDX_W'(i)) begin
            r_mem[i] <= INIT_VAL;
          end
        end else if (w_we && (w_widx == IDX_W'(i))) begin
          r_mem[i] <= w_wdata;
        end
      end
    end
  end

  // Sticky firmware seal; a request in the rising cycle still sees the old value
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sealed <= 1'b0;
    end else if (boot_done_i) begin
      r_sealed <= 1'b1;
    end
  end

  // Round-robin pointer: preference moves to the requester that was not just served
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_dbg <= 1'b0;
    end else if (w_fw_win) begin
      r_rr_dbg <= 1'b1;
    end else if (w_dbg_win) begin
      r_rr_dbg <= 1'b0;
    end
  end

  // Registered grant, deny and init-done outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fw_gnt    <= 1'b0;
      r_dbg_gnt   <= 1'b0;
      r_deny      <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_fw_gnt    <= w_fw_win;
      r_dbg_gnt   <= w_dbg_win;
      r_deny      <= w_deny;
      r_init_done <= (w_state_nxt == ST_RUN);
    end
  end

  assign fw_gnt_o    = r_fw_gnt;
  assign dbg_gnt_o   = r_dbg_gnt;
  assign deny_o      = r_deny;
  assign init_done_o = r_init_done;
  assign reglk_mem_o = r_mem;

`ifdef REGLK_AUDIT_EN
  logic [15:0]      r_deny_cnt;
  logic [IDX_W-1:0] r_last_deny_idx;

  // Denial audit: saturating count and last denied index, cleared only by rst_i
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_deny_cnt      <= 16'h0000;
      r_last_deny_idx <= '0;
    end else if (w_deny) begin
      if (r_deny_cnt != 16'hFFFF) begin
        r_deny_cnt <= r_deny_cnt + 16'h0001;
      end
      r_last_deny_idx <= w_widx;
    end
  end

  assign deny_cnt_o      = r_deny_cnt;
  assign last_deny_idx_o = r_last_deny_idx;
`endif

  reglk_ctrl_chk u_chk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .fw_gnt_i    (r_fw_gnt),
    .dbg_gnt_i   (r_dbg_gnt),
    .deny_i      (r_deny),
    .init_done_i (r_init_done)
  );

endmodule

// Protocol checker for reglk_ctrl outputs.
module reglk_ctrl_chk (
  input logic clk_i,
  input logic rst_i,
  input logic fw_gnt_i,
  input logic dbg_gnt_i,
  input logic deny_i,
  input logic init_done_i
);

  a_one_grant: assert property (@(posedge clk_i) disable iff (rst_i) !(fw_gnt_i && dbg_gnt_i));
  a_deny_with_gnt: assert property (@(posedge clk_i) disable iff (rst_i) deny_i |-> (fw_gnt_i || dbg_gnt_i));
  a_gnt_in_run: assert property (@(posedge clk_i) disable iff (rst_i) (fw_gnt_i || dbg_gnt_i) |-> init_done_i);

endmodule

// File: tb/tb_reglk_ctrl.sv
// Randomized bench for reglk_ctrl against a cycle-level behavioural model of the lock array.
module tb_reglk_ctrl;

  localparam int NUM_REGS = 6;
  localparam int DATA_W   = 32;
  localparam int IDX_W    = 3;
  localparam int VW       = NUM_REGS * DATA_W;

  logic clk_i = 1'b0;
  logic rst_i, soft_rst_i, boot_done_i, jtag_unlock_i;
  logic fw_req_i, dbg_req_i;
  logic [IDX_W-1:0] fw_idx_i, dbg_idx_i;
  logic [DATA_W-1:0] fw_wdata_i, dbg_wdata_i;
  logic fw_gnt_o, dbg_gnt_o, deny_o, init_done_o;
  logic [NUM_REGS-1:0][DATA_W-1:0] reglk_mem_o;
`ifdef REGLK_AUDIT_EN
  logic [15:0] deny_cnt_o;
  logic [IDX_W-1:0] last_deny_idx_o;
`endif

  reglk_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .soft_rst_i    (soft_rst_i),
    .boot_done_i   (boot_done_i),
    .jtag_unlock_i (jtag_unlock_i),
    .fw_req_i      (fw_req_i),
    .fw_idx_i      (fw_idx_i),
    .fw_wdata_i    (fw_wdata_i),
    .fw_gnt_o      (fw_gnt_o),
    .dbg_req_i     (dbg_req_i),
    .dbg_idx_i     (dbg_idx_i),
    .dbg_wdata_i   (dbg_wdata_i),
    .dbg_gnt_o     (dbg_gnt_o),
    .deny_o        (deny_o),
    .init_done_o   (init_done_o),
    .reglk_mem_o   (reglk_mem_o)
`ifdef REGLK_AUDIT_EN
    ,
    .deny_cnt_o      (deny_cnt_o),
    .last_deny_idx_o (last_deny_idx_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [DATA_W-1:0] m_mem [NUM_REGS];
  bit m_run, m_sealed, m_pref_dbg, m_fw_gnt, m_dbg_gnt, m_deny;
  int m_pos, m_deny_cnt, m_last_idx;
  bit fw_pend, dbg_pend;

  task automatic chk_val(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NUM_REGS; i++) m_mem[i] = '1;
    m_run = 0; m_pos = 0; m_sealed = 0; m_pref_dbg = 0;
    m_fw_gnt = 0; m_dbg_gnt = 0; m_deny = 0;
    m_deny_cnt = 0; m_last_idx = 0;
  endtask

  // One clock of the specification's rules applied to the inputs currently driven
  task automatic m_step();
    bit fe, de, fw_w, dbg_w, ok;
    int idx;
    logic [DATA_W-1:0] d;
    fw_w = 0; dbg_w = 0; ok = 0;
    if (!m_run) begin
      m_mem[m_pos] = '1;
      if (soft_rst_i) m_pos = 0;
      else if (m_pos == NUM_REGS - 1) begin m_run = 1; m_pos = 0; end
      else m_pos++;
    end else if (soft_rst_i) begin
      m_run = 0; m_pos = 0;
    end else begin
      fe = fw_req_i && !m_fw_gnt;
      de = dbg_req_i && !m_dbg_gnt;
      if (fe && de) begin
        if (m_pref_dbg) dbg_w = 1; else fw_w = 1;
      end else begin
        fw_w = fe; dbg_w = de;
      end
      if (fw_w) m_pref_dbg = 1;
      if (dbg_w) m_pref_dbg = 0;
    end
    idx = dbg_w ? int'(dbg_idx_i) : int'(fw_idx_i);
    d   = dbg_w ? dbg_wdata_i : fw_wdata_i;
    if (fw_w) ok = !m_sealed && (idx < NUM_REGS);
    if (dbg_w) ok = jtag_unlock_i && (idx < NUM_REGS);
    if ((fw_w || dbg_w) && ok) m_mem[idx] = d;
    m_deny = (fw_w || dbg_w) && !ok;
    if (m_deny) begin
      if (m_deny_cnt < 65535) m_deny_cnt++;
      m_last_idx = idx;
    end
    m_fw_gnt = fw_w;
    m_dbg_gnt = dbg_w;
    if (boot_done_i) m_sealed = 1;
  endtask

  function automatic logic [VW-1:0] m_mem_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < NUM_REGS; i++) v[i*DATA_W +: DATA_W] = m_mem[i];
    return v;
  endfunction

  task automatic check_outputs();
    chk_val("fw_gnt", VW'(fw_gnt_o), VW'(m_fw_gnt));
    chk_val("dbg_gnt", VW'(dbg_gnt_o), VW'(m_dbg_gnt));
    chk_val("deny", VW'(deny_o), VW'(m_deny));
    chk_val("init_done", VW'(init_done_o), VW'(m_run));
    chk_val("mem", reglk_mem_o, m_mem_vec());
`ifdef REGLK_AUDIT_EN
    chk_val("deny_cnt", VW'(deny_cnt_o), VW'(m_deny_cnt));
    chk_val("last_deny_idx", VW'(last_deny_idx_o), VW'(m_last_idx));
`endif
  endtask

  task automatic drive_cycle(input int soft_pct, input int boot_per, input int jtag_pct);
    if (!fw_pend && ($urandom_range(0, 2) == 0)) begin
      fw_pend    = 1;
      fw_idx_i   = IDX_W'($urandom_range(0, 7));
      fw_wdata_i = ($urandom_range(0, 3) == 0) ? 32'h0000_0000 : DATA_W'($urandom);
    end
    if (!dbg_pend && ($urandom_range(0, 2) == 0)) begin
      dbg_pend    = 1;
      dbg_idx_i   = IDX_W'($urandom_range(0, 7));
      dbg_wdata_i = DATA_W'($urandom);
    end
    fw_req_i      = fw_pend;
    dbg_req_i     = dbg_pend;
    soft_rst_i    = ($urandom_range(0, 99) < soft_pct);
    boot_done_i   = (boot_per > 0) && ($urandom_range(0, boot_per - 1) == 0);
    jtag_unlock_i = ($urandom_range(0, 99) < jtag_pct);
    m_step();
    @(posedge clk_i);
    #1;
    check_outputs();
    if (m_fw_gnt) fw_pend = 0;
    if (m_dbg_gnt) dbg_pend = 0;
  endtask

  task automatic async_reset_midcycle();
    #3;
    rst_i = 1'b1;
    #1;
    chk_val("rst_mem_all_ones", reglk_mem_o, {VW{1'b1}});
    chk_val("rst_init_done", VW'(init_done_o), VW'(1'b0));
    chk_val("rst_gnts", VW'({fw_gnt_o, dbg_gnt_o, deny_o}), VW'(3'b000));
    m_reset();
    fw_pend = 0; dbg_pend = 0;
    fw_req_i = 1'b0; dbg_req_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; soft_rst_i = 1'b0; boot_done_i = 1'b0; jtag_unlock_i = 1'b0;
    fw_req_i = 1'b0; dbg_req_i = 1'b0;
    fw_idx_i = '0; dbg_idx_i = '0; fw_wdata_i = '0; dbg_wdata_i = '0;
    fw_pend = 0; dbg_pend = 0;
    m_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_outputs();
    rst_i = 1'b0;

    // Unsealed firmware, mostly unlocked debug, occasional soft resets
    for (int c = 0; c < 400; c++) drive_cycle(2, 0, 70);
    // Seal arrives at a random point; soft resets must not unseal
    for (int c = 0; c < 400; c++) drive_cycle(2, 120, 50);
    async_reset_midcycle();
    // After a hard reset firmware is unsealed again; debug mostly locked
    for (int c = 0; c < 300; c++) drive_cycle(3, 200, 20);
    async_reset_midcycle();
    for (int c = 0; c < 200; c++) drive_cycle(0, 0, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
